// File: rtl/output_weight_update.sv
// Output-layer SGD weight update: 8 weights, one written per cycle; sweep is 9 cycles from start to done_o, en_i=0 stalls everything.
// No backpressure: start_i is accepted only from IDLE. OWU_SATURATE_EN selects clamping instead of wrapping on the new weight.
module output_weight_update #(
  parameter int X_W      = 10,
  parameter int ERR_W    = 12,
  parameter int WEIGHT_W = 8,
  parameter int SHIFT    = 6,
  parameter int INIT_W   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic [ERR_W-1:0]      error_i,
  input  logic [8*X_W-1:0]      x_i,
  output logic [8*WEIGHT_W-1:0] w_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int N   = 8;
  localparam int P_W = ERR_W + X_W + 1;
  localparam int N_W = P_W + 1;
  localparam logic [WEIGHT_W-1:0] INIT_VAL = WEIGHT_W'(INIT_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic [N*X_W-1:0]        x_q, x_d;
  logic [N*WEIGHT_W-1:0]   w_q, w_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [X_W-1:0]          x_sel;
  logic [WEIGHT_W-1:0]     w_sel;
  logic signed [P_W-1:0]   err_ext;
  logic signed [P_W-1:0]   x_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   dlt;
  logic signed [N_W-1:0]   w_ext;
  logic signed [N_W-1:0]   d_ext;
  logic signed [N_W-1:0]   n_full;
  logic [WEIGHT_W-1:0]     w_new;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      err_q   <= '0;
      x_q     <= '0;
      w_q     <= {N{INIT_VAL}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      x_q     <= x_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        IDLE:    if (start_i) state_d = UPDATE;
        UPDATE:  if (idx_q == 3'd7) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered status outputs follow the state being entered
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    if (en_i) begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
    end
  end

  // Update arithmetic: p = err * x[idx], d = p >>> SHIFT, n = w[idx] - d
  always_comb begin
    x_sel   = x_q[idx_q*X_W +: X_W];
    w_sel   = w_q[idx_q*WEIGHT_W +: WEIGHT_W];
    err_ext = {{(P_W-ERR_W){err_q[ERR_W-1]}}, err_q};
    x_ext   = {{(P_W-X_W){1'b0}}, x_sel};
    prod    = err_ext * x_ext;
    dlt     = prod >>> SHIFT;
    w_ext   = {{(N_W-WEIGHT_W){w_sel[WEIGHT_W-1]}}, w_sel};
    d_ext   = {dlt[P_W-1], dlt};
    n_full  = w_ext - d_ext;
  end

`ifdef OWU_SATURATE_EN
  localparam logic signed [N_W-1:0] W_MAX = {{(N_W-WEIGHT_W+1){1'b0}}, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [N_W-1:0] W_MIN = {{(N_W-WEIGHT_W+1){1'b1}}, {(WEIGHT_W-1){1'b0}}};

  always_comb begin
    if (n_full > W_MAX)      w_new = W_MAX[WEIGHT_W-1:0];
    else if (n_full < W_MIN) w_new = W_MIN[WEIGHT_W-1:0];
    else                     w_new = n_full[WEIGHT_W-1:0];
  end
`else
  logic unused_n_hi;

  // Two's-complement wrap: upper bits of n are simply dropped
  assign w_new       = n_full[WEIGHT_W-1:0];
  assign unused_n_hi = ^n_full[N_W-1:WEIGHT_W];
`endif

  // Operand capture, index walk and weight write-back
  always_comb begin
    idx_d = idx_q;
    err_d = err_q;
    x_d   = x_q;
    w_d   = w_q;
    if (en_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            err_d = error_i;
            x_d   = x_i;
            idx_d = 3'd0;
          end
        end
        UPDATE: begin
          w_d[idx_q*WEIGHT_W +: WEIGHT_W] = w_new;
          idx_d = idx_q + 3'd1;
        end
        default: idx_d = 3'd0;
      endcase
    end
  end

  assign w_o    = w_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_output_weight_update.sv
// Scoreboarded bench: sweeps push expected final weights and busy length; a monitor checks them on each done_o.
module tb_output_weight_update;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        start_i;
  logic [11:0] error_i;
  logic [79:0] x_i;
  logic [63:0] w_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic [63:0] w;
    int          busy;
  } exp_t;

  exp_t sb[$];

  output_weight_update dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .start_i(start_i),
    .error_i(error_i),
    .x_i    (x_i),
    .w_o    (w_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    en_i    = 1'b1;
    start_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Monitor: counts busy cycles, compares against scoreboard on done_o
  initial begin : monitor
    int   busy_cnt;
    logic prev_done;
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
      else        busy_cnt = 0;
      if (prev_done) chk("done_one_cycle", {63'd0, done_o}, 64'd0);
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending sweep");
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_weights"}, w_o, e.w);
          chk({e.nm, "_busy_len"}, 64'(busy_cnt), 64'(e.busy));
        end
      end
      prev_done = done_o;
    end
  end

  // Full sweep from reset; extra_at/stall_at < 0 disable those disturbances
  task automatic run(input string nm, input logic [11:0] err, input logic [79:0] x,
                     input logic [63:0] exp_w, input int extra_at, input int stall_at,
                     input int exp_busy);
    exp_t e;
    logic idle;
    logic [63:0] snap;
    do_reset();
    e.nm = nm; e.w = exp_w; e.busy = exp_busy;
    sb.push_back(e);
    error_i = err;
    x_i     = x;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    error_i = 12'h5a5;
    x_i     = {8{10'h3ff}};
    chk({nm, "_busy_at_e0"}, {63'd0, busy_o}, 64'd1);
    idle = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == stall_at) begin
        snap = w_o;
        en_i = 1'b0;
        repeat (3) tick();
        chk({nm, "_stall_hold"}, w_o, snap);
        chk({nm, "_stall_busy"}, {63'd0, busy_o}, 64'd1);
        en_i = 1'b1;
      end
      if (c == extra_at) begin
        start_i = 1'b1;
        error_i = 12'd500;
        x_i     = {8{10'd1}};
      end
      tick();
      start_i = 1'b0;
      if (stall_at < 0 && c <= 8) begin
        chk($sformatf("%s_w%0d_at_e%0d", nm, c - 1, c), 64'(w_o[(c-1)*8 +: 8]), 64'(exp_w[(c-1)*8 +: 8]));
        if (c < 8)
          chk($sformatf("%s_w%0d_unchanged", nm, c), 64'(w_o[c*8 +: 8]), 64'd1);
      end
      if (!busy_o) begin
        idle = 1'b1;
        break;
      end
    end
    chk({nm, "_reached_idle"}, {63'd0, idle}, 64'd1);
    tick();
    tick();
    chk({nm, "_stays_idle"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin : stim
    logic [79:0] x_lane;
    logic [63:0] w_lane;
    logic [63:0] w_sat;
    rst_i   = 1'b1;
    en_i    = 1'b1;
    start_i = 1'b0;
    error_i = '0;
    x_i     = '0;

    do_reset();
    chk("reset_w", w_o, {8{8'h01}});
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_done", {63'd0, done_o}, 64'd0);

    run("basic", 12'd64, {8{10'd1}}, {8{8'h00}}, -1, -1, 9);
    run("neg640", 12'hd80, {8{10'd10}}, {8{8'h65}}, -1, -1, 9);
    run("neg1_floor", 12'hfff, {8{10'd1}}, {8{8'h02}}, -1, -1, 9);
`ifdef OWU_SATURATE_EN
    w_sat = {8{8'h80}};
`else
    w_sat = {8{8'h31}};
`endif
    run("saturate", 12'd2047, {8{10'd1023}}, w_sat, -1, -1, 9);

    for (int k = 0; k < 8; k++) begin
      x_lane[k*10 +: 10] = 10'(10 * k);
      w_lane[k*8 +: 8]   = 8'(1 - 10 * k);
    end
    run("per_lane", 12'd64, x_lane, w_lane, -1, -1, 9);
    run("err_zero", 12'd0, {8{10'd77}}, {8{8'h01}}, -1, -1, 9);
    run("extra_start", 12'd64, {8{10'd1}}, {8{8'h00}}, 3, -1, 9);
    run("start_at_done", 12'd64, {8{10'd1}}, {8{8'h00}}, 9, -1, 9);
    run("stall_en", 12'd64, {8{10'd1}}, {8{8'h00}}, -1, 4, 12);

    // start_i with en_i low is dropped
    do_reset();
    en_i    = 1'b0;
    start_i = 1'b1;
    error_i = 12'd64;
    x_i     = {8{10'd1}};
    tick();
    start_i = 1'b0;
    en_i    = 1'b1;
    tick();
    tick();
    chk("start_lost_busy", {63'd0, busy_o}, 64'd0);
    chk("start_lost_w", w_o, {8{8'h01}});

    // Reset in the middle of a sweep
    do_reset();
    error_i = 12'd64;
    x_i     = {8{10'd1}};
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    chk("mid_w_before_rst", 64'(w_o[7:0]), 64'd0);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_w", w_o, {8{8'h01}});
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_done", {63'd0, done_o}, 64'd0);
    rst_i = 1'b0;
    repeat (12) tick();
    chk("mid_rst_idle", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_w_after", w_o, {8{8'h01}});

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
